// File: rtl/mips_pkg.sv
// Shared MIPS core constants and basic register-file types.
package mips_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;
  localparam logic [AW_DEF-1:0] REG_RA   = 5'd31;

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/gpr_file_mp_if.sv
// Decode-stage GPR file bus: read ports, two write ports, issue and scoreboard view.
interface gpr_file_mp_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [DW-1:0]       wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [DW-1:0]       wd1;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [(1<<AW)-1:0]  busy_vec;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on collision.
module gpr_scoreboard import mips_pkg::*; #(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_iss_en,
  input  logic [AW-1:0]        i_iss_addr,
  input  logic                 i_we0,
  input  logic [AW-1:0]        i_wa0,
  input  logic                 i_we1,
  input  logic [AW-1:0]        i_wa1,
  output logic [(1<<AW)-1:0]   o_busy
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_en) w_set[i_iss_addr] = 1'b1;
    if (ZERO_REG != 0) w_set[0] = 1'b0;
    if (i_we0) w_clr[i_wa0] = 1'b1;
    if (i_we1) w_clr[i_wa1] = 1'b1;
  end

  // A newly issued instruction owns the register even if an older write retires now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_set | (r_busy & ~w_clr);
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with prioritised dual write, optional write-through and busy scoreboard.
module gpr_file_mp import mips_pkg::*; #(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic           clk,
  input logic           reset,
  gpr_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    r_rf [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_wr0;
  logic             w_wr1;

  assign w_wr0 = bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
  assign w_wr1 = bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < DEPTH; n++) r_rf[n] <= '0;
    end else begin
      if (w_wr0) r_rf[bus.wa0] <= bus.wd0;
      if (w_wr1) r_rf[bus.wa1] <= bus.wd1;
    end
  end

  gpr_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .i_we0      (bus.we0),
    .i_wa0      (bus.wa0),
    .i_we1      (bus.we1),
    .i_wa1      (bus.wa1),
    .o_busy     (w_busy)
  );

  assign bus.busy_vec = w_busy;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_zero;
    logic          w_hit0;
    logic          w_hit1;
    logic [DW-1:0] w_data;

    assign w_addr = bus.rd_addr[g*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_hit1 = (BYPASS != 0) && bus.we1 && (bus.wa1 == w_addr) && !w_zero;
    assign w_hit0 = (BYPASS != 0) && bus.we0 && (bus.wa0 == w_addr) && !w_zero;

    always_comb begin
      w_data = r_rf[w_addr];
      if (w_hit1)      w_data = bus.wd1;
      else if (w_hit0) w_data = bus.wd0;
      if (reset || w_zero) w_data = '0;
    end

    // Forwarded data makes the pending write irrelevant to the reader.
    assign bus.rd_data[g*DW +: DW] = w_data;
    assign bus.rd_busy[g] = !reset && w_busy[w_addr] && !(w_hit0 || w_hit1);
  end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: bypassing and non-bypassing instances share one stimulus.
module tb_gpr_file_mp;
  logic        clk;
  logic        reset;
  logic [4:0]  ra0, ra1;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;

  int checks;
  int failures;

  gpr_file_mp_if #(.DW(32), .AW(5), .NRD(2)) bus_a ();
  gpr_file_mp_if #(.DW(32), .AW(5), .NRD(2)) bus_b ();

  assign bus_a.rd_addr  = {ra1, ra0};
  assign bus_a.we0      = we0;
  assign bus_a.wa0      = wa0;
  assign bus_a.wd0      = wd0;
  assign bus_a.we1      = we1;
  assign bus_a.wa1      = wa1;
  assign bus_a.wd1      = wd1;
  assign bus_a.iss_en   = iss_en;
  assign bus_a.iss_addr = iss_addr;

  assign bus_b.rd_addr  = {ra1, ra0};
  assign bus_b.we0      = we0;
  assign bus_b.wa0      = wa0;
  assign bus_b.wd0      = wd0;
  assign bus_b.we1      = we1;
  assign bus_b.wa1      = wa1;
  assign bus_b.wd1      = wd1;
  assign bus_b.iss_en   = iss_en;
  assign bus_b.iss_addr = iss_addr;

  gpr_file_mp #(.DW(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  gpr_file_mp #(.DW(32), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    ra0 = 5'd3; ra1 = 5'd31;
    idle();
    #2;
    check("rst_rd0", bus_a.rd_data[31:0], 32'h0);
    check("rst_busy", bus_a.busy_vec, 32'h0);
    step();
    reset = 1'b0;
    #1;

    // Pre-write 3 and 31, issue 5, then reset over them.
    we1 = 1'b1; wa1 = 5'd3;  wd1 = 32'h0000AAAA;
    we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h0000BBBB;
    iss_en = 1'b1; iss_addr = 5'd5;
    step();
    idle();
    #1;
    check("pre_rd3", bus_a.rd_data[31:0], 32'h0000AAAA);
    check("pre_rd31", bus_a.rd_data[63:32], 32'h0000BBBB);
    check("pre_busy", bus_a.busy_vec, 32'h00000020);
    reset = 1'b1;
    #1;
    check("rstw_rd3", bus_a.rd_data[31:0], 32'h0);
    check("rstw_rd31", bus_a.rd_data[63:32], 32'h0);
    check("rstw_busy", bus_a.busy_vec, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("post_rd3", bus_a.rd_data[31:0], 32'h0);
    check("post_rd31", bus_a.rd_data[63:32], 32'h0);
    check("post_busy", bus_a.busy_vec, 32'h0);

    // Dual write to one address: port 1 wins.
    ra0 = 5'd7; ra1 = 5'd7;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hDEADBEEF;
    #1;
    check("prio_byp", bus_a.rd_data[31:0], 32'hDEADBEEF);
    check("prio_nb_old", bus_b.rd_data[31:0], 32'h0);
    step();
    idle();
    #1;
    check("prio_rf", bus_a.rd_data[63:32], 32'hDEADBEEF);
    check("prio_nb_rf", bus_b.rd_data[31:0], 32'hDEADBEEF);

    // Register zero ignores writes and issues.
    ra0 = 5'd0;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    #1;
    check("zero_byp", bus_a.rd_data[31:0], 32'h0);
    check("zero_rdbusy", 32'(bus_a.rd_busy[0]), 32'h0);
    step();
    idle();
    #1;
    check("zero_rd", bus_a.rd_data[31:0], 32'h0);
    check("zero_busy", bus_a.busy_vec, 32'h0);

    // Non-bypass instance sees the new value only after the edge.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0BADF00D;
    step();
    ra0 = 5'd5;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678;
    #1;
    check("nb_old", bus_b.rd_data[31:0], 32'h0BADF00D);
    check("byp_new", bus_a.rd_data[31:0], 32'h12345678);
    step();
    idle();
    #1;
    check("nb_new", bus_b.rd_data[31:0], 32'h12345678);

    // Scoreboard: issue 9, hold, write 9, then collide issue and write.
    ra0 = 5'd9; ra1 = 5'd5;
    iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    check("sb_iss_now", 32'(bus_a.rd_busy[0]), 32'h0);
    step();
    idle();
    #1;
    check("sb_busy", 32'(bus_a.rd_busy[0]), 32'h1);
    check("sb_other", 32'(bus_a.rd_busy[1]), 32'h0);
    check("sb_vec", bus_a.busy_vec, 32'h00000200);
    step();
    check("sb_hold", 32'(bus_a.rd_busy[0]), 32'h1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFEF00D;
    #1;
    check("sb_wr_byp", 32'(bus_a.rd_busy[0]), 32'h0);
    check("sb_wr_nb", 32'(bus_b.rd_busy[0]), 32'h1);
    check("sb_wr_vec", bus_a.busy_vec, 32'h00000200);
    step();
    idle();
    #1;
    check("sb_clr", bus_a.busy_vec, 32'h0);
    check("sb_clr_nb", 32'(bus_b.rd_busy[0]), 32'h0);
    iss_en = 1'b1; iss_addr = 5'd9;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99999999;
    step();
    idle();
    #1;
    check("sb_setwins", bus_a.busy_vec, 32'h00000200);
    check("sb_setwins_rd", bus_a.rd_data[31:0], 32'h99999999);

    // Async reset between edges with 7 and 9 busy; reset also blocks a write.
    iss_en = 1'b1; iss_addr = 5'd7;
    step();
    idle();
    #1;
    check("ar_pre", bus_a.busy_vec, 32'h00000280);
    reset = 1'b1;
    #1;
    check("ar_drop", bus_a.busy_vec, 32'h0);
    check("ar_drop_nb", bus_b.busy_vec, 32'h0);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55555555;
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    idle();
    reset = 1'b0;
    #1;
    check("ar_nowr", bus_a.rd_data[31:0], 32'h0);
    check("ar_noiss", bus_a.busy_vec, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
